// File: rtl/iomem_burst_reader_if.sv
// SoC iomem valid/ready bus as seen between one initiator and one responder.
// The master modport is the initiator side; the slave modport is the responder side.
interface iomem_burst_reader_if;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;

  modport master (
    output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
    input  iomem_ready, iomem_rdata
  );

  modport slave (
    input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
    output iomem_ready, iomem_rdata
  );
endinterface

// File: rtl/iomem_burst_reader.sv
// Read-only burst initiator on the iomem bus: one read per commanded word, with
// the returned data queued in a small FIFO and streamed out on a valid/ready port.
module iomem_burst_reader #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 255,
  parameter int ADDR_STEP  = 4
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [31:0]                 cmd_addr,
  input  logic [7:0]                  cmd_len,
  input  logic                        cmd_incr,
  input  logic                        abort,
  iomem_burst_reader_if.master        iomem,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [31:0]                 out_data,
  output logic                        busy,
  output logic                        done,
  output logic                        timeout_err
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, FINISH} state_e;

  state_e          state_q;
  logic [31:0]     addr_q;
  logic [7:0]      remain_q;
  logic            incr_q;
  logic            abort_q;
  logic            valid_q;
  logic            cmd_ready_q;
  logic            busy_q;
  logic            done_q;
  logic            terr_q;
  logic [TW-1:0]   tmo_q;

  logic [31:0]     mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wptr_q, rptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic            has_space;
  logic            push;
  logic            pop;

  assign has_space = (count_q < CW'(FIFO_DEPTH));
  assign push      = (state_q == REQ) && iomem.iomem_ready;
  assign pop       = (count_q != '0) && out_ready;

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the values from before the edge regardless of statement order.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remain_q    <= '0;
      incr_q      <= 1'b0;
      abort_q     <= 1'b0;
      valid_q     <= 1'b0;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      terr_q      <= 1'b0;
      tmo_q       <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          cmd_ready_q <= 1'b1;
          if (cmd_valid && cmd_ready_q) begin
            addr_q      <= cmd_addr;
            remain_q    <= cmd_len;
            incr_q      <= cmd_incr;
            terr_q      <= 1'b0;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            tmo_q       <= '0;
            if (cmd_len == 8'd0) begin
              state_q <= FINISH;
              done_q  <= 1'b1;
            end else if (has_space) begin
              state_q <= REQ;
              valid_q <= 1'b1;
            end else begin
              state_q <= WAIT;
            end
          end
        end
        REQ: begin
          // Valid may not drop before ready, so abort is only remembered here.
          if (abort) abort_q <= 1'b1;
          if (iomem.iomem_ready) begin
            remain_q <= remain_q - 8'd1;
            if (incr_q) addr_q <= addr_q + 32'(ADDR_STEP);
            valid_q  <= 1'b0;
            state_q  <= WAIT;
          end else if (TIMEOUT != 0 && tmo_q == TW'(TIMEOUT - 1)) begin
            terr_q  <= 1'b1;
            valid_q <= 1'b0;
            state_q <= FINISH;
            done_q  <= 1'b1;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        WAIT: begin
          if (remain_q == 8'd0 || abort || abort_q) begin
            state_q <= FINISH;
            done_q  <= 1'b1;
          end else if (has_space) begin
            state_q <= REQ;
            valid_q <= 1'b1;
            tmo_q   <= '0;
          end
        end
        FINISH: begin
          state_q     <= IDLE;
          abort_q     <= 1'b0;
          busy_q      <= 1'b0;
          cmd_ready_q <= 1'b1;
        end
      endcase
    end
  end

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path can leave it holding a stale value and infer a latch.
  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // NOTE: the storage array has no reset; entries are only read after a push,
  // and the pointers/count alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= iomem.iomem_rdata;
  end

  assign iomem.iomem_valid = valid_q;
  assign iomem.iomem_addr  = addr_q;
  assign iomem.iomem_wstrb = 4'b0000;
  assign iomem.iomem_wdata = 32'h0;

  assign cmd_ready   = cmd_ready_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout_err = terr_q;
  assign out_valid   = (count_q != '0);
  assign out_data    = mem_q[rptr_q];

endmodule

// File: tb/tb_iomem_burst_reader.sv
// Self-checking bench for iomem_burst_reader: a negedge responder model feeds a
// scoreboard of returned words, which is drained and compared on the output stream.
module tb_iomem_burst_reader;
  localparam int DEPTH = 4;
  localparam int TMO   = 8;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_addr = '0;
  logic [7:0]  cmd_len = '0;
  logic        cmd_incr = 1'b0;
  logic        abort = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        busy, done, timeout_err;

  iomem_burst_reader_if bus();

  iomem_burst_reader #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TMO), .ADDR_STEP(4)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_addr    (cmd_addr),
    .cmd_len     (cmd_len),
    .cmd_incr    (cmd_incr),
    .abort       (abort),
    .iomem       (bus),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .busy        (busy),
    .done        (done),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Responder model and scoreboard producer
  logic [31:0] pre_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] addr_log[$];
  int          resp_delay = 1;
  bit          resp_en = 1'b1;
  int          wait_cnt = 0;
  logic [31:0] start_addr = '0;
  logic [31:0] seq = 32'hA000_0000;

  initial begin
    logic [31:0] data;
    bus.iomem_ready = 1'b0;
    bus.iomem_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.iomem_ready) check("idle_gap", bus.iomem_valid, 1'b0);
      bus.iomem_ready = 1'b0;
      if (bus.iomem_valid && resp_en && resetn) begin
        wait_cnt++;
        if (wait_cnt == 1) start_addr = bus.iomem_addr;
        if (wait_cnt >= resp_delay) begin
          if (pre_q.size() > 0) data = pre_q.pop_front();
          else begin
            data = seq;
            seq  = seq + 32'h0000_0101;
          end
          bus.iomem_ready = 1'b1;
          bus.iomem_rdata = data;
          exp_q.push_back(data);
          addr_log.push_back(bus.iomem_addr);
          check("addr_stable", bus.iomem_addr, start_addr);
          check("wstrb_zero", {28'h0, bus.iomem_wstrb}, 32'h0);
          check("wdata_zero", bus.iomem_wdata, 32'h0);
          wait_cnt = 0;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Output stream consumer and event counters
  int pops = 0;
  int done_cnt = 0;
  int valid_cycles = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (done) done_cnt++;
      if (bus.iomem_valid) valid_cycles++;
      if (resetn && out_valid && out_ready) begin
        pops++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL stream_extra: got %h expected no word", out_data);
        end else begin
          check("stream_data", out_data, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] log_at(input int i);
    if (i < addr_log.size()) return addr_log[i];
    return 32'hxxxx_xxxx;
  endfunction

  task automatic send_cmd(input logic [31:0] a, input int len, input bit incr);
    int n = 0;
    while (!cmd_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("cmd_ready_wait", {31'h0, cmd_ready}, 32'h1);
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_len   = 8'(len);
    cmd_incr  = incr;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check("burst_end", {31'h0, busy}, 32'h0);
  endtask

  typedef struct {
    logic [31:0] addr;
    int          len;
    bit          incr;
    int          delay;
    logic [31:0] last_addr;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int d0, p0, v0, n;

    vecs[0] = '{32'h0300_1000, 3, 1'b0, 2, 32'h0300_1000};
    vecs[1] = '{32'hFFFF_FFFC, 2, 1'b1, 1, 32'h0000_0000};
    vecs[2] = '{32'h0300_0000, 6, 1'b1, 1, 32'h0300_0014};
    vecs[3] = '{32'h0000_1000, 1, 1'b1, 3, 32'h0000_1000};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid",     {31'h0, bus.iomem_valid}, 32'h0);
    check("rst_addr",      bus.iomem_addr, 32'h0);
    check("rst_cmd_ready", {31'h0, cmd_ready}, 32'h0);
    check("rst_busy",      {31'h0, busy}, 32'h0);
    check("rst_done",      {31'h0, done}, 32'h0);
    check("rst_terr",      {31'h0, timeout_err}, 32'h0);
    check("rst_out_valid", {31'h0, out_valid}, 32'h0);
    resetn = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("idle_cmd_ready", {31'h0, cmd_ready}, 32'h1);

    // Table-driven bursts with the consumer always ready
    out_ready = 1'b1;
    pre_q = {32'h11, 32'h22, 32'h33};
    for (int i = 0; i < 4; i++) begin
      addr_log.delete();
      d0 = done_cnt;
      p0 = pops;
      resp_delay = vecs[i].delay;
      send_cmd(vecs[i].addr, vecs[i].len, vecs[i].incr);
      wait_idle(400);
      repeat (3) @(posedge clk);
      #1;
      check($sformatf("v%0d_reads", i), addr_log.size(), vecs[i].len);
      check($sformatf("v%0d_first", i), log_at(0), vecs[i].addr);
      check($sformatf("v%0d_last", i), log_at(vecs[i].len - 1), vecs[i].last_addr);
      check($sformatf("v%0d_done", i), done_cnt - d0, 1);
      check($sformatf("v%0d_words", i), pops - p0, vecs[i].len);
      check($sformatf("v%0d_terr", i), {31'h0, timeout_err}, 32'h0);
    end

    // Zero length: done the cycle after accept, ready again the cycle after that
    v0 = valid_cycles;
    d0 = done_cnt;
    send_cmd(32'h0300_1000, 0, 1'b1);
    check("zl_done", {31'h0, done}, 32'h1);
    @(posedge clk); #1;
    check("zl_cmd_ready", {31'h0, cmd_ready}, 32'h1);
    check("zl_done_clear", {31'h0, done}, 32'h0);
    check("zl_no_valid", valid_cycles - v0, 0);
    check("zl_done_cnt", done_cnt - d0, 1);

    // Backpressure: FIFO fills after four reads, fifth read waits for a pop
    out_ready = 1'b0;
    addr_log.delete();
    resp_delay = 1;
    d0 = done_cnt;
    send_cmd(32'h0300_0FFC, 5, 1'b1);
    n = 0;
    while (addr_log.size() < 4 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (8) @(posedge clk);
    #1;
    check("bp_reads",   addr_log.size(), 4);
    check("bp_addr0",   log_at(0), 32'h0300_0FFC);
    check("bp_addr1",   log_at(1), 32'h0300_1000);
    check("bp_addr2",   log_at(2), 32'h0300_1004);
    check("bp_addr3",   log_at(3), 32'h0300_1008);
    check("bp_stalled", {31'h0, bus.iomem_valid}, 32'h0);
    check("bp_busy",    {31'h0, busy}, 32'h1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    wait_idle(100);
    check("bp_reads5", addr_log.size(), 5);
    check("bp_addr4",  log_at(4), 32'h0300_100C);
    check("bp_done",   done_cnt - d0, 1);
    out_ready = 1'b1;
    n = 0;
    while (out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("bp_drained", exp_q.size(), 0);

    // Timeout: responder silent
    resp_en = 1'b0;
    v0 = valid_cycles;
    d0 = done_cnt;
    send_cmd(32'h0300_2000, 4, 1'b0);
    wait_idle(100);
    check("to_valid_cycles", valid_cycles - v0, TMO);
    check("to_err",          {31'h0, timeout_err}, 32'h1);
    check("to_done",         done_cnt - d0, 1);
    check("to_out_empty",    {31'h0, out_valid}, 32'h0);
    resp_en = 1'b1;
    addr_log.delete();
    send_cmd(32'h0300_2000, 1, 1'b0);
    check("to_err_cleared", {31'h0, timeout_err}, 32'h0);
    wait_idle(100);
    repeat (3) @(posedge clk);
    #1;
    check("to_recover_reads", addr_log.size(), 1);

    // Abort during the third request
    addr_log.delete();
    resp_delay = 2;
    d0 = done_cnt;
    p0 = pops;
    send_cmd(32'h0300_3000, 10, 1'b1);
    n = 0;
    while (!(bus.iomem_valid && addr_log.size() == 2) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("ab_third_req", {31'h0, bus.iomem_valid}, 32'h1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    wait_idle(100);
    repeat (3) @(posedge clk);
    #1;
    check("ab_reads", addr_log.size(), 3);
    check("ab_addr2", log_at(2), 32'h0300_3008);
    check("ab_done",  done_cnt - d0, 1);
    check("ab_words", pops - p0, 3);

    // Reset while a request is outstanding
    out_ready = 1'b0;
    addr_log.delete();
    resp_delay = 2;
    send_cmd(32'h0300_4000, 3, 1'b1);
    n = 0;
    while (!(bus.iomem_valid && addr_log.size() == 1) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("mr_fifo_loaded", {31'h0, out_valid}, 32'h1);
    resetn = 1'b0;
    @(posedge clk); #1;
    check("mr_valid",     {31'h0, bus.iomem_valid}, 32'h0);
    check("mr_out_valid", {31'h0, out_valid}, 32'h0);
    check("mr_busy",      {31'h0, busy}, 32'h0);
    exp_q.delete();
    resetn = 1'b1;
    out_ready = 1'b1;
    addr_log.delete();
    d0 = done_cnt;
    p0 = pops;
    send_cmd(32'h0300_1000, 1, 1'b0);
    wait_idle(100);
    repeat (3) @(posedge clk);
    #1;
    check("mr_after_reads", addr_log.size(), 1);
    check("mr_after_addr",  log_at(0), 32'h0300_1000);
    check("mr_after_done",  done_cnt - d0, 1);
    check("mr_after_words", pops - p0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
